// File: rtl/ps2_tx.sv
// rtl/ps2_tx.sv - Host-to-device PS/2 command byte transmitter.
// Drives the open-drain clock/data lines only while busy; pads are external.
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RELEASE, S_SEND, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [8:0]      shift_q, shift_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic            ack_ok_q, ack_ok_d;
  logic            ack_err_q, ack_err_d;
  logic [2:0]      clk_sync_q, clk_sync_d;
  logic [2:0]      data_sync_q, data_sync_d;
  logic            clk_dl_q, clk_dl_d;
  logic            data_dl_q, data_dl_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  logic fall;
  logic line_idle;
  logic timed_out;

  assign fall      = (clk_sync_q[2:1] == 2'b10);
  assign line_idle = clk_sync_q[2] & data_sync_q[2];
  assign timed_out = (cnt_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    ack_ok_d    = ack_ok_q;
    ack_err_d   = ack_err_q;
    clk_dl_d    = clk_dl_q;
    data_dl_d   = data_dl_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    clk_sync_d  = {clk_sync_q[1:0], ps2_clk_in};
    data_sync_d = {data_sync_q[1:0], ps2_data_in};

    unique case (state_q)
      S_IDLE: begin
        clk_dl_d  = 1'b0;
        data_dl_d = 1'b0;
        cnt_d     = '0;
        if (tx_valid) begin
          shift_d   = {~^tx_data, tx_data};
          bit_cnt_d = '0;
          ack_ok_d  = 1'b0;
          ack_err_d = 1'b0;
          clk_dl_d  = 1'b1;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          data_dl_d = 1'b1;
          state_d   = S_RELEASE;
        end
      end
      S_RELEASE: begin
        clk_dl_d  = 1'b0;
        cnt_d     = '0;
        bit_cnt_d = '0;
        state_d   = S_SEND;
      end
      S_SEND: begin
        // Stop bit falls out of the shift register as 1s are shifted in behind parity.
        if (fall) begin
          cnt_d     = '0;
          data_dl_d = ~shift_q[0];
          shift_d   = {1'b1, shift_q[8:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) state_d = S_ACK;
        end else if (timed_out) begin
          clk_dl_d  = 1'b0;
          data_dl_d = 1'b0;
          error_d   = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_ACK: begin
        if (fall) begin
          cnt_d     = '0;
          ack_ok_d  = ~data_sync_q[2];
          ack_err_d = data_sync_q[2];
          state_d   = S_WAIT_IDLE;
        end else if (timed_out) begin
          clk_dl_d  = 1'b0;
          data_dl_d = 1'b0;
          error_d   = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (fall) cnt_d = '0;
        if (line_idle) begin
          done_d  = ack_ok_q;
          error_d = ack_err_q;
          state_d = S_IDLE;
        end else if (timed_out && !fall) begin
          clk_dl_d  = 1'b0;
          data_dl_d = 1'b0;
          error_d   = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      ack_ok_q    <= 1'b0;
      ack_err_q   <= 1'b0;
      clk_sync_q  <= 3'b111;
      data_sync_q <= 3'b111;
      clk_dl_q    <= 1'b0;
      data_dl_q   <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      ack_ok_q    <= ack_ok_d;
      ack_err_q   <= ack_err_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_dl_q    <= clk_dl_d;
      data_dl_q   <= data_dl_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign tx_ready           = (state_q == S_IDLE);
  assign busy               = (state_q != S_IDLE);
  assign ps2_clk_drive_low  = clk_dl_q;
  assign ps2_data_drive_low = data_dl_q;
  assign done               = done_q;
  assign error              = error_q;

endmodule

// File: tb/tb_ps2_tx.sv
// tb/tb_ps2_tx.sv - Self-checking bench for ps2_tx with a behavioural PS/2 device.
module tb_ps2_tx;
  localparam int INH = 2000;
  localparam int TO  = 500;
  localparam int H   = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, error;
  logic       ps2_clk_drive_low, ps2_data_drive_low;
  logic       ps2_clk_in, ps2_data_in;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int inh_seen, both_seen;
  logic start_seen;
  logic [9:0] rx_bits;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_drive_low;
  assign ps2_data_in = dev_data & ~ps2_data_drive_low;

  always #5 clk = ~clk;

  ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_drive_low(ps2_clk_drive_low), .ps2_data_drive_low(ps2_data_drive_low),
    .busy(busy), .done(done), .error(error)
  );

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (error) err_cnt++;
  end

  // Expected bits after falling edges 1..10: d0..d7, odd parity, stop.
  function automatic logic [9:0] expect_frame(input logic [7:0] d);
    int ones = 0;
    logic [9:0] f;
    for (int i = 0; i < 8; i++) begin
      f[i] = d[i];
      ones += int'(d[i]);
    end
    f[8] = (ones % 2 == 0);
    f[9] = 1'b1;
    return f;
  endfunction

  task automatic device(input int nedges, input bit ack);
    int t = 0;
    inh_seen = 0;
    both_seen = 0;
    rx_bits = '0;
    while (!ps2_clk_drive_low && t < 200) begin
      @(negedge clk);
      t++;
    end
    while (ps2_clk_drive_low && t < 4 * INH) begin
      if (ps2_data_drive_low) both_seen++;
      else inh_seen++;
      @(negedge clk);
      t++;
    end
    start_seen = ps2_data_in;
    repeat (H) @(negedge clk);
    for (int i = 1; i <= nedges; i++) begin
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      if (i <= 10) rx_bits[i-1] = ps2_data_in;
      dev_clk = 1'b1;
      if (i == 10 && ack) dev_data = 1'b0;
      if (i == 11) dev_data = 1'b1;
      repeat (H) @(negedge clk);
    end
    dev_data = 1'b1;
  endtask

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_flag(input int d0, input int e0, input int limit);
    int t = 0;
    while (done_cnt == d0 && err_cnt == e0 && t < limit) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] d);
    int d0 = done_cnt;
    int e0 = err_cnt;
    logic [9:0] exp_f = expect_frame(d);
    total++;
    if (tx_ready !== 1'b1) begin bad++; $display("FAIL ready_before got=%b exp=1", tx_ready); end
    start_tx(d);
    device(11, 1'b1);
    wait_flag(d0, e0, 200);
    total++;
    if (inh_seen != INH) begin bad++; $display("FAIL inhibit_len data=%h got=%0d exp=%0d", d, inh_seen, INH); end
    total++;
    if (both_seen != 1 || start_seen !== 1'b0) begin
      bad++; $display("FAIL start_bit data=%h got=%0d/%b exp=1/0", d, both_seen, start_seen);
    end
    total++;
    if (rx_bits !== exp_f) begin bad++; $display("FAIL frame data=%h got=%b exp=%b", d, rx_bits, exp_f); end
    total++;
    if (done_cnt - d0 != 1 || err_cnt != e0) begin
      bad++; $display("FAIL done_pulse data=%h got=%0d/%0d exp=1/0", d, done_cnt - d0, err_cnt - e0);
    end
    total++;
    if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL ready_after data=%h got=%b%b exp=10", d, tx_ready, busy);
    end
  endtask

  task automatic test_reset();
    total++;
    if ({tx_ready, busy, ps2_clk_drive_low, ps2_data_drive_low, done, error} !== 6'b100000) begin
      bad++;
      $display("FAIL reset_state got=%b exp=100000",
               {tx_ready, busy, ps2_clk_drive_low, ps2_data_drive_low, done, error});
    end
  endtask

  task automatic test_basic();
    run_frame(8'hED);
  endtask

  task automatic test_parity();
    run_frame(8'h01);
    run_frame(8'h00);
    run_frame(8'hFF);
    run_frame(8'($urandom));
  endtask

  task automatic test_nack();
    int d0 = done_cnt;
    int e0 = err_cnt;
    logic [7:0] d = 8'($urandom);
    start_tx(d);
    device(11, 1'b0);
    wait_flag(d0, e0, 200);
    total++;
    if (rx_bits !== expect_frame(d)) begin bad++; $display("FAIL nack_frame got=%b exp=%b", rx_bits, expect_frame(d)); end
    total++;
    if (err_cnt - e0 != 1 || done_cnt != d0) begin
      bad++; $display("FAIL nack_flags got=%0d/%0d exp=1/0", err_cnt - e0, done_cnt - d0);
    end
    total++;
    if (tx_ready !== 1'b1) begin bad++; $display("FAIL nack_ready got=%b exp=1", tx_ready); end
  endtask

  task automatic test_timeout();
    int d0 = done_cnt;
    int e0 = err_cnt;
    int w = 0;
    start_tx(8'($urandom));
    device(4, 1'b1);
    while (err_cnt == e0 && w < 4 * TO) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (err_cnt - e0 != 1 || done_cnt != d0) begin
      bad++; $display("FAIL timeout_flags got=%0d/%0d exp=1/0", err_cnt - e0, done_cnt - d0);
    end
    total++;
    if (w < TO - 2 * H - 2 || w > TO - 2 * H + 8) begin
      bad++; $display("FAIL timeout_delay got=%0d exp=%0d", w, TO - 2 * H + 3);
    end
    total++;
    if ({ps2_clk_drive_low, ps2_data_drive_low, tx_ready, busy} !== 4'b0010) begin
      bad++;
      $display("FAIL timeout_release got=%b exp=0010",
               {ps2_clk_drive_low, ps2_data_drive_low, tx_ready, busy});
    end
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    int e0 = err_cnt;
    logic [9:0] f1, f2;
    fork
      begin
        device(11, 1'b1);
        f1 = rx_bits;
        device(11, 1'b1);
        f2 = rx_bits;
      end
      begin
        int t = 0;
        @(negedge clk);
        tx_data = 8'hF4;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h55;
        while (done_cnt == d0 && t < 4 * INH) begin
          @(negedge clk);
          t++;
        end
        t = 0;
        while (!busy && t < 20) begin
          @(negedge clk);
          t++;
        end
        tx_valid = 1'b0;
      end
    join
    wait_flag(d0 + 1, e0, 200);
    total++;
    if (f1 !== expect_frame(8'hF4)) begin bad++; $display("FAIL b2b_first got=%b exp=%b", f1, expect_frame(8'hF4)); end
    total++;
    if (f2 !== expect_frame(8'h55)) begin bad++; $display("FAIL b2b_second got=%b exp=%b", f2, expect_frame(8'h55)); end
    total++;
    if (done_cnt - d0 != 2 || err_cnt != e0) begin
      bad++; $display("FAIL b2b_flags got=%0d/%0d exp=2/0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_reset_midsend();
    int d0, e0;
    start_tx(8'hF0);
    device(3, 1'b1);
    total++;
    if (busy !== 1'b1 || ps2_data_drive_low !== 1'b1) begin
      bad++; $display("FAIL midsend_state got=%b%b exp=11", busy, ps2_data_drive_low);
    end
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({ps2_clk_drive_low, ps2_data_drive_low, tx_ready} !== 3'b001) begin
      bad++; $display("FAIL async_release got=%b exp=001", {ps2_clk_drive_low, ps2_data_drive_low, tx_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    e0 = err_cnt;
    repeat (2 * TO) @(negedge clk);
    total++;
    if (done_cnt != d0 || err_cnt != e0 || tx_ready !== 1'b1) begin
      bad++; $display("FAIL post_reset got=%0d/%0d/%b exp=0/0/1", done_cnt - d0, err_cnt - e0, tx_ready);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    test_basic();
    test_parity();
    test_nack();
    test_timeout();
    test_back_to_back();
    test_reset_midsend();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
